vdot_pipe: RTL and testbench

//  Parametrised, fully pipelined packed-SIMD dot-product unit for the EXE stage.

---
 rtl/vdot_pipe_pkg.sv | 24 ++
 rtl/vdot_pipe_if.sv | 26 ++
 rtl/vdot_pipe_add_tree.sv | 28 ++
 rtl/vdot_pipe.sv | 154 +++++++++++++++
 tb/tb_vdot_pipe.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/vdot_pipe_pkg.sv
// rtl/vdot_pipe_pkg.sv - shared constants and parameter legality check for the VDOT pipe
package vdot_pipe_pkg;

  localparam int VDOT_EW_8    = 8;
  localparam int VDOT_EW_16   = 16;
  localparam int VDOT_EW_32   = 32;
  localparam int VDOT_LAT_MIN = 2;
  localparam int VDOT_LAT_MAX = 8;

  // EXE result-source encodings used when aligning VDOT with the other units
  typedef enum logic [1:0] {
    OP_ALU = 2'd0,
    OP_MEM = 2'd1,
    OP_MUL = 2'd2
  } op_type_e;

  function automatic bit params_legal(input int xlen, input int ew, input int lat);
    bit ew_ok;
    ew_ok = (ew == VDOT_EW_8) || (ew == VDOT_EW_16) || (ew == VDOT_EW_32);
    return ew_ok && (ew <= xlen) && ((xlen % ew) == 0) &&
           (lat >= VDOT_LAT_MIN) && (lat <= VDOT_LAT_MAX);
  endfunction

endpackage

// File: rtl/vdot_pipe_if.sv
// rtl/vdot_pipe_if.sv - operand/result bundle between EXE issue logic and the VDOT pipe
interface vdot_pipe_if #(
  parameter int XLEN = 32,
  parameter int TAGW = 5
);
  logic            in_valid;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            sgn;
  logic            acc;
  logic [TAGW-1:0] tag_in;
  logic            out_valid;
  logic [XLEN-1:0] res;
  logic [TAGW-1:0] tag_out;
  logic            busy;

  modport master (
    output in_valid, A, B, sgn, acc, tag_in,
    input  out_valid, res, tag_out, busy
  );

  modport slave (
    input  in_valid, A, B, sgn, acc, tag_in,
    output out_valid, res, tag_out, busy
  );
endinterface

// File: rtl/vdot_pipe_add_tree.sv
// rtl/vdot_pipe_add_tree.sv - combinational sum of lane products, sign- or zero-extended
module vdot_pipe_add_tree #(
  parameter int LANES = 4,
  parameter int IW    = 16,
  parameter int OW    = 32
) (
  input  logic [LANES*IW-1:0] terms,
  input  logic                sgn,
  output logic [OW-1:0]       sum
);

  localparam int SW = (OW > IW) ? OW : IW;

  logic [SW-1:0] acc_w;
  logic [SW-1:0] ext;

  always_comb begin
    acc_w = '0;
    ext   = '0;
    for (int i = 0; i < LANES; i++) begin
      ext   = sgn ? SW'($signed(terms[i*IW +: IW])) : SW'(terms[i*IW +: IW]);
      acc_w = acc_w + ext;
    end
  end

  assign sum = acc_w[OW-1:0];

endmodule

// File: rtl/vdot_pipe.sv
// rtl/vdot_pipe.sv - pipelined packed-SIMD dot product with running accumulator
module vdot_pipe
  import vdot_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int EW   = 8,
  parameter int LAT  = 3,
  parameter int TAGW = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         EN,
  input  logic         flush,
  input  logic         acc_clr,
  vdot_pipe_if.slave   bus
);

  localparam int LANES = XLEN / EW;
  localparam int PW    = 2 * EW;
  localparam int ND    = LAT - 2;

  if (!params_legal(XLEN, EW, LAT)) begin : g_bad_params
    $error("vdot_pipe: illegal XLEN/EW/LAT combination");
  end

  logic [LANES*PW-1:0] prod_d;
  logic [PW-1:0]       ea, eb;

  always_comb begin
    prod_d = '0;
    ea     = '0;
    eb     = '0;
    for (int i = 0; i < LANES; i++) begin
      ea = bus.sgn ? PW'($signed(bus.A[i*EW +: EW])) : PW'(bus.A[i*EW +: EW]);
      eb = bus.sgn ? PW'($signed(bus.B[i*EW +: EW])) : PW'(bus.B[i*EW +: EW]);
      prod_d[i*PW +: PW] = ea * eb;
    end
  end

  logic                s1_v, s1_sgn, s1_acc;
  logic [TAGW-1:0]     s1_tag;
  logic [LANES*PW-1:0] s1_prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_sgn  <= 1'b0;
      s1_acc  <= 1'b0;
      s1_tag  <= '0;
      s1_prod <= '0;
    end else begin
      if (flush)   s1_v <= 1'b0;
      else if (EN) s1_v <= bus.in_valid;
      if (EN) begin
        s1_sgn  <= bus.sgn;
        s1_acc  <= bus.acc;
        s1_tag  <= bus.tag_in;
        s1_prod <= prod_d;
      end
    end
  end

  logic [XLEN-1:0] tree_sum;

  vdot_pipe_add_tree #(.LANES(LANES), .IW(PW), .OW(XLEN)) u_tree (
    .terms (s1_prod),
    .sgn   (s1_sgn),
    .sum   (tree_sum)
  );

  logic            fin_v, fin_acc, dly_busy;
  logic [TAGW-1:0] fin_tag;
  logic [XLEN-1:0] fin_sum;

  // With LAT=2 the tree output feeds the final stage directly
  if (ND == 0) begin : g_nodly
    assign fin_v    = s1_v;
    assign fin_acc  = s1_acc;
    assign fin_tag  = s1_tag;
    assign fin_sum  = tree_sum;
    assign dly_busy = 1'b0;
  end else begin : g_dly
    logic [ND-1:0]   d_v, d_acc;
    logic [TAGW-1:0] d_tag [ND];
    logic [XLEN-1:0] d_sum [ND];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        d_v   <= '0;
        d_acc <= '0;
        for (int k = 0; k < ND; k++) begin
          d_tag[k] <= '0;
          d_sum[k] <= '0;
        end
      end else begin
        if (flush) d_v <= '0;
        else if (EN) begin
          d_v[0] <= s1_v;
          for (int k = 1; k < ND; k++) d_v[k] <= d_v[k-1];
        end
        if (EN) begin
          d_acc[0] <= s1_acc;
          d_tag[0] <= s1_tag;
          d_sum[0] <= tree_sum;
          for (int k = 1; k < ND; k++) begin
            d_acc[k] <= d_acc[k-1];
            d_tag[k] <= d_tag[k-1];
            d_sum[k] <= d_sum[k-1];
          end
        end
      end
    end

    assign fin_v    = d_v[ND-1];
    assign fin_acc  = d_acc[ND-1];
    assign fin_tag  = d_tag[ND-1];
    assign fin_sum  = d_sum[ND-1];
    assign dly_busy = |d_v;
  end

  logic            out_v_q;
  logic [XLEN-1:0] res_q, acc_q, r;
  logic [TAGW-1:0] tag_q;
  logic            fin_take, acc_we;

  // acc_q is read and written in the same stage so back-to-back acc ops chain
  assign r        = fin_sum + (fin_acc ? acc_q : '0);
  assign fin_take = EN && fin_v && !flush;
  assign acc_we   = fin_take && fin_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_v_q <= 1'b0;
      res_q   <= '0;
      tag_q   <= '0;
      acc_q   <= '0;
    end else begin
      if (flush)   out_v_q <= 1'b0;
      else if (EN) out_v_q <= fin_v;
      if (fin_take) begin
        res_q <= r;
        tag_q <= fin_tag;
      end
      if (acc_clr)     acc_q <= '0;
      else if (acc_we) acc_q <= r;
    end
  end

  assign bus.out_valid = out_v_q;
  assign bus.res       = res_q;
  assign bus.tag_out   = tag_q;
  assign bus.busy      = s1_v | dly_busy | out_v_q;

endmodule

// File: tb/tb_vdot_pipe.sv
// tb/tb_vdot_pipe.sv - directed self-checking bench for vdot_pipe
module tb_vdot_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en, flush, acc_clr;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vdot_pipe_if #(.XLEN(32), .TAGW(5)) b8 ();
  vdot_pipe_if #(.XLEN(32), .TAGW(5)) b16 ();

  vdot_pipe #(.XLEN(32), .EW(8), .LAT(3), .TAGW(5)) u8 (
    .clk     (clk),
    .rst     (rst),
    .EN      (en),
    .flush   (flush),
    .acc_clr (acc_clr),
    .bus     (b8)
  );

  vdot_pipe #(.XLEN(32), .EW(16), .LAT(4), .TAGW(5)) u16 (
    .clk     (clk),
    .rst     (rst),
    .EN      (en),
    .flush   (flush),
    .acc_clr (acc_clr),
    .bus     (b16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op8(input logic v, input logic [31:0] a, input logic [31:0] b,
                     input logic s, input logic ac, input logic [4:0] tg);
    b8.in_valid = v;
    b8.A        = a;
    b8.B        = b;
    b8.sgn      = s;
    b8.acc      = ac;
    b8.tag_in   = tg;
  endtask

  task automatic op16(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic ac, input logic [4:0] tg);
    b16.in_valid = v;
    b16.A        = a;
    b16.B        = b;
    b16.sgn      = s;
    b16.acc      = ac;
    b16.tag_in   = tg;
  endtask

  task automatic out8(input string tag, input logic v, input logic [31:0] r, input logic [4:0] tg);
    chk({tag, "_valid"}, 64'(b8.out_valid), 64'(v));
    chk({tag, "_res"}, 64'(b8.res), 64'(r));
    chk({tag, "_tag"}, 64'(b8.tag_out), 64'(tg));
  endtask

  initial begin
    en = 1'b1; flush = 1'b0; acc_clr = 1'b0;
    op8(0, 0, 0, 0, 0, 0);
    op16(0, 0, 0, 0, 0, 0);

    #1 rst = 1'b1;
    #3;
    out8("reset", 0, 32'h0, 5'd0);
    chk("reset_busy", 64'(b8.busy), 64'd0);
    @(negedge clk) rst = 1'b0;
    step();

    // basic unsigned, latency exactly 3
    op8(1, 32'h01020304, 32'h01010101, 0, 0, 5'd7);
    step(); op8(0, 0, 0, 0, 0, 0);
    chk("busy_inflight", 64'(b8.busy), 64'd1);
    step(); chk("lat_early", 64'(b8.out_valid), 64'd0);
    step(); out8("basic", 1, 32'h0000000A, 5'd7);

    // all-ones lanes, signed then unsigned
    op8(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 5'd1);
    step(); op8(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 5'd2);
    step(); op8(0, 0, 0, 0, 0, 0);
    step(); out8("ones_s", 1, 32'h00000004, 5'd1);
    step(); out8("ones_u", 1, 32'h0003F804, 5'd2);
    step(); out8("ones_hold", 0, 32'h0003F804, 5'd2);

    // accumulator chaining
    acc_clr = 1'b1; op8(1, 32'h01020304, 32'h01010101, 0, 1, 5'd3);
    step(); acc_clr = 1'b0; op8(1, 32'h0000000A, 32'h00000001, 0, 1, 5'd4);
    step(); op8(1, 32'h05000000, 32'h02000000, 0, 1, 5'd5);
    step(); op8(0, 0, 0, 0, 0, 0);
    out8("acc1", 1, 32'd10, 5'd3);
    step(); out8("acc2", 1, 32'd20, 5'd4);
    step(); out8("acc3", 1, 32'd30, 5'd5);

    // stall: W emerges as the stall starts, X in flight, Y waits at the input
    op8(1, 32'h10203040, 32'h01010101, 0, 0, 5'd10);
    step(); op8(0, 0, 0, 0, 0, 0);
    step(); op8(1, 32'h01020304, 32'h01010101, 0, 0, 5'd8);
    step(); op8(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 5'd9); en = 1'b0;
    out8("stall_w", 1, 32'h000000A0, 5'd10);
    step(); out8("stall_hold1", 1, 32'h000000A0, 5'd10);
    step(); en = 1'b1; out8("stall_hold2", 1, 32'h000000A0, 5'd10);
    step(); op8(0, 0, 0, 0, 0, 0);
    out8("stall_bubble", 0, 32'h000000A0, 5'd10);
    step(); out8("stall_x", 1, 32'h0000000A, 5'd8);
    step(); out8("stall_y", 1, 32'h00000004, 5'd9);
    step(); chk("stall_nodup", 64'(b8.out_valid), 64'd0);

    // flush (with EN low in the same cycle) kills two acc ops, acc_q untouched
    op8(1, 32'h01020304, 32'h01010101, 0, 1, 5'd11);
    step(); op8(1, 32'h01020304, 32'h01010101, 0, 1, 5'd12); flush = 1'b1; en = 1'b0;
    step(); flush = 1'b0; en = 1'b1; op8(1, 32'h0000000A, 32'h00000001, 0, 1, 5'd13);
    chk("flush_busy", 64'(b8.busy), 64'd0);
    step(); op8(0, 0, 0, 0, 0, 0);
    chk("flush_v3", 64'(b8.out_valid), 64'd0);
    step(); chk("flush_v4", 64'(b8.out_valid), 64'd0);
    step(); out8("flush_z", 1, 32'd40, 5'd13);
    step(); chk("flush_v6", 64'(b8.out_valid), 64'd0);

    // acc_clr beats a final-stage acc write
    op8(1, 32'h0000000A, 32'h00000001, 0, 1, 5'd14);
    step(); op8(1, 32'h0000000A, 32'h00000001, 0, 1, 5'd15);
    step(); op8(0, 0, 0, 0, 0, 0); acc_clr = 1'b1;
    step(); acc_clr = 1'b0;
    out8("clr_p", 1, 32'd50, 5'd14);
    step(); out8("clr_q", 1, 32'd10, 5'd15);

    // EW=16, LAT=4 instance, then async reset mid-stream
    op16(1, 32'h7FFF7FFF, 32'h7FFF7FFF, 1, 0, 5'd21);
    step(); op16(1, 32'h7FFF7FFF, 32'h00010001, 1, 0, 5'd22);
    step(); op16(1, 32'h7FFF7FFF, 32'h7FFF7FFF, 1, 0, 5'd23);
    step(); op16(0, 0, 0, 0, 0, 0);
    chk("w16_early", 64'(b16.out_valid), 64'd0);
    step();
    chk("w16_valid", 64'(b16.out_valid), 64'd1);
    chk("w16_res", 64'(b16.res), 64'h7FFE0002);
    chk("w16_tag", 64'(b16.tag_out), 64'd21);
    step();
    chk("w16_res2", 64'(b16.res), 64'h0000FFFE);
    chk("w16_tag2", 64'(b16.tag_out), 64'd22);
    #2 rst = 1'b1;
    #1;
    chk("arst16_valid", 64'(b16.out_valid), 64'd0);
    chk("arst16_res", 64'(b16.res), 64'd0);
    chk("arst16_tag", 64'(b16.tag_out), 64'd0);
    chk("arst16_busy", 64'(b16.busy), 64'd0);
    out8("arst8", 0, 32'h0, 5'd0);
    #10 rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
